// File: rtl/ps2_rx_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
// Frame layout (device to host): start(0), 8 data bits LSB first, odd parity, stop(1).
`timescale 1ns/1ps
package ps2_pkg;

   // Receiver FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DPS  = 2'd1,
      ST_LOAD = 2'd2
   } ps2_state_e;

   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = 8;
   // Bits captured after the start bit: data, parity, stop
   localparam int SHIFT_BITS = FRAME_BITS - 1;

   // Scan-code prefixes consumed by the flag and decoder stages
   localparam logic [7:0] BREAK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE   = 8'hE0;

   // Odd parity holds when data plus parity bit contain an odd number of ones
   function automatic logic odd_parity_ok(input logic [DATA_BITS:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/ps2_rx_filter.sv
// ps2_filter: 2-FF synchronisers on ps2c/ps2d, FILTER_LEN-deep debounce on the
// clock line, and a one-cycle fall_edge pulse on the filtered clock.
// Raw ps2c fall to fall_edge asserted: 2 + FILTER_LEN clock edges.
`timescale 1ns/1ps
module ps2_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c,
   input  logic ps2d,
   output logic ps2d_s,
   output logic fall_edge
);

   logic                  c_meta_q, c_sync_q;
   logic                  d_meta_q, d_sync_q;
   logic [FILTER_LEN-1:0] filt_q, filt_d;
   logic                  fclk_q, fclk_d;
   logic                  fall_q, fall_d;

   // Debounce: the filtered clock only moves once the whole window agrees
   always_comb begin
      filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q};
      fclk_d = fclk_q;
      fall_d = 1'b0;
      if (&filt_d) begin
         fclk_d = 1'b1;
      end else if (~|filt_d) begin
         fclk_d = 1'b0;
      end
      fall_d = fclk_q & ~fclk_d;
   end

   // Synchronisers and filter state; idle line is high so everything resets to 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_meta_q <= 1'b1;
         c_sync_q <= 1'b1;
         d_meta_q <= 1'b1;
         d_sync_q <= 1'b1;
         filt_q   <= '1;
         fclk_q   <= 1'b1;
         fall_q   <= 1'b0;
      end else begin
         c_meta_q <= ps2c;
         c_sync_q <= c_meta_q;
         d_meta_q <= ps2d;
         d_sync_q <= d_meta_q;
         filt_q   <= filt_d;
         fclk_q   <= fclk_d;
         fall_q   <= fall_d;
      end
   end

   assign ps2d_s    = d_sync_q;
   assign fall_edge = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Deserialises start/8 data/parity/stop on filtered ps2c falling edges and
// emits a one-cycle rx_done_tick with dout holding the new scan code.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity
// (parity_err pulse); otherwise parity is ignored and parity_err stays 0.
// Handshake: rx_done_tick, parity_err and frame_err are mutually exclusive
// single-cycle pulses; dout is valid while rx_done_tick is high and holds
// until the next good frame.
`timescale 1ns/1ps
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2d,
   input  logic             ps2c,
   input  logic             rx_en,
   output logic [7:0]       dout,
   output logic             rx_done_tick,
   output logic             parity_err,
   output logic             frame_err,
   output ps2_state_e       dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   // Last count value before the abort fires; abort lands TIMEOUT_CYC-1 cycles after the last edge
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

   logic ps2d_s, fall_edge;

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2c      (ps2c),
      .ps2d      (ps2d),
      .ps2d_s    (ps2d_s),
      .fall_edge (fall_edge)
   );

   ps2_state_e           state_q, state_d;
   logic [3:0]           n_q, n_d;
   logic [SHIFT_BITS-1:0] b_q, b_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [7:0]           dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 parity_bad;

   // Next-state and result decode; outcome pulses are registered so they
   // appear in the LOAD cycle, one cycle after the stop-bit edge
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      b_d        = b_q;
      tmo_d      = tmo_q;
      dout_d     = dout_q;
      done_d     = 1'b0;
      perr_d     = 1'b0;
      ferr_d     = 1'b0;
      parity_bad = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall_edge && rx_en && !ps2d_s) begin
               n_d     = 4'd0;
               tmo_d   = '0;
               state_d = ST_DPS;
            end
         end
         ST_DPS: begin
            if (fall_edge) begin
               b_d   = {ps2d_s, b_q[SHIFT_BITS-1:1]};
               n_d   = n_q + 4'd1;
               tmo_d = '0;
`ifdef PS2_PARITY_CHECK_EN
               parity_bad = !odd_parity_ok(b_d[DATA_BITS:0]);
`else
               parity_bad = 1'b0;
`endif
               // Tenth shift carries the stop bit
               if (n_q == 4'd9) begin
                  state_d = ST_LOAD;
                  if (!b_d[SHIFT_BITS-1]) begin
                     ferr_d = 1'b1;
                  end else if (parity_bad) begin
                     perr_d = 1'b1;
                  end else begin
                     done_d = 1'b1;
                     dout_d = b_d[DATA_BITS-1:0];
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               ferr_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_LOAD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         n_q     <= 4'd0;
         b_q     <= '0;
         tmo_q   <= '0;
         dout_q  <= 8'h00;
         done_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tmo_q   <= tmo_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign parity_err   = perr_q;
   assign frame_err    = ferr_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames on a slow PS/2 clock; expected events are queued
// by the drivers and matched by an independent monitor.
`timescale 1ns/1ps
module tb_ps2_rx;
   import ps2_pkg::*;

   localparam int FL   = 8;
   localparam int TMO  = 200;
   localparam int HALF = 40;   // PS/2 clock half period in system cycles

   localparam logic [1:0] K_DONE = 2'd0;
   localparam logic [1:0] K_PERR = 2'd1;
   localparam logic [1:0] K_FERR = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset, ps2d, ps2c, rx_en;
   logic [7:0] dout;
   logic tick, perr, ferr;
   ps2_state_e dbg_state;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2d         (ps2d),
      .ps2c         (ps2c),
      .rx_en        (rx_en),
      .dout         (dout),
      .rx_done_tick (tick),
      .parity_err   (perr),
      .frame_err    (ferr),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [9:0] exp_q[$];
   logic [7:0] last_good;
   int unsigned last_fall_cyc = 0;
   int unsigned ferr_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   task automatic ps2_bit(input logic v);
      @(negedge clk) ps2d = v;
      repeat (HALF/2) @(negedge clk);
      ps2c = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2c = 1'b1;
      repeat (HALF/2) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
   endtask

   task automatic send_good(input logic [7:0] d);
      exp_q.push_back({K_DONE, d});
      last_good = d;
      send_bits(mk_frame(d, ~^d, 1'b1), 11);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!reset && (tick || perr || ferr)) begin
         logic [1:0] kind;
         kind = tick ? K_DONE : (perr ? K_PERR : K_FERR);
         check("one_pulse", 32'(tick) + 32'(perr) + 32'(ferr), 32'd1);
         if (ferr) ferr_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d dout %0h expected none", kind, dout);
         end else begin
            check("event", {22'b0, kind, dout}, {22'b0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int unsigned dt;
      reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; last_good = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_dout", dout, 8'h00);
      check("rst_tick", tick, 1'b0);
      check("rst_perr", perr, 1'b0);
      check("rst_ferr", ferr, 1'b0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge clk) reset = 1'b0;
      repeat (20) @(negedge clk);

      // single good frame
      send_good(8'h1C);
      check("dout_1c", dout, 8'h1C);

      // back-to-back frames
      send_good(8'hF0);
      check("dout_f0", dout, 8'hF0);
      send_good(8'h1C);
      check("dout_1c_b2b", dout, 8'h1C);
      send_good(8'hF0);

      // 0x1C with wrong parity bit (1)
`ifdef PS2_PARITY_CHECK_EN
      exp_q.push_back({K_PERR, last_good});
`else
      exp_q.push_back({K_DONE, 8'h1C});
      last_good = 8'h1C;
`endif
      send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
      check("dout_after_parity", dout, last_good);

      // stop bit 0 then recovery
      exp_q.push_back({K_FERR, last_good});
      send_bits(mk_frame(8'h55, ~^8'h55, 1'b0), 11);
      check("dout_after_stop0", dout, last_good);
      send_good(8'h32);
      check("dout_32", dout, 8'h32);

      // clock stops after 4 data bits: abort after the timeout window
      exp_q.push_back({K_FERR, last_good});
      ferr_cyc = 0;
      send_bits(mk_frame(8'hA5, ~^8'hA5, 1'b1), 5);
      repeat (TMO + 50) @(negedge clk);
      // raw fall -> fall_edge (2+FL) -> state update (+1) -> abort (+TMO-1)
      dt = ferr_cyc - last_fall_cyc;
      total++;
      if (ferr_cyc == 0 || dt < 32'(FL + 1 + TMO) || dt > 32'(FL + 3 + TMO)) begin
         bad++;
         $display("FAIL timeout_latency: got %0d expected %0d", dt, FL + 2 + TMO);
      end
      check("state_after_timeout", dbg_state, ST_IDLE);
      send_good(8'h2B);
      check("dout_2b", dout, 8'h2B);

      // short ps2c glitches with data low must not start a frame
      ps2d = 1'b0;
      for (int g = 0; g < 3; g++) begin
         @(negedge clk) ps2c = 1'b0;
         repeat (FL - 3) @(negedge clk);
         ps2c = 1'b1;
         repeat (20) @(negedge clk);
      end
      ps2d = 1'b1;
      check("state_after_glitch", dbg_state, ST_IDLE);
      send_good(8'h3A);
      check("dout_3a", dout, 8'h3A);

      // receiver disabled for a whole frame
      rx_en = 1'b0;
      send_bits(mk_frame(8'h4E, ~^8'h4E, 1'b1), 11);
      rx_en = 1'b1;
      check("dout_rx_dis", dout, 8'h3A);

      // rx_en dropped after the start bit does not abort
      begin
         logic [10:0] fr;
         fr = mk_frame(8'h69, ~^8'h69, 1'b1);
         exp_q.push_back({K_DONE, 8'h69});
         last_good = 8'h69;
         ps2_bit(fr[0]);
         rx_en = 1'b0;
         for (int i = 1; i < 11; i++) ps2_bit(fr[i]);
         rx_en = 1'b1;
      end
      check("dout_69", dout, 8'h69);

      // reset in the middle of a frame
      send_bits(mk_frame(8'h77, ~^8'h77, 1'b1), 6);
      @(negedge clk) reset = 1'b1;
      #1;
      check("midrst_dout", dout, 8'h00);
      check("midrst_tick", tick, 1'b0);
      check("midrst_perr", perr, 1'b0);
      check("midrst_ferr", ferr, 1'b0);
      check("midrst_state", dbg_state, ST_IDLE);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      last_good = 8'h00;
      repeat (20) @(negedge clk);
      send_good(8'h12);
      check("dout_12", dout, 8'h12);

      repeat (50) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
